// File: rtl/alarm_pkg.sv
// Shared encodings for alarm_mode_ctrl: display modes, alarm states, timer width helper.
// Optional snooze support is selected by defining ALARM_SNOOZE_EN.
package alarm_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_t;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    AL_IDLE    = 2'b00,
    AL_RINGING = 2'b01,
    AL_SNOOZE  = 2'b10
  } alarm_state_t;
`else
  typedef enum logic [1:0] {
    AL_IDLE    = 2'b00,
    AL_RINGING = 2'b01
  } alarm_state_t;
`endif

  // Width that holds the larger of the two second counts.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = int'($clog2(m + 1));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_if.sv
// Bus between the clock front-end and alarm_mode_ctrl: tick, buttons, times and status.
interface alarm_mode_ctrl_if;
  logic       Tick_1Hz;
  logic       BTN_MODE;
  logic       BTN_SNOOZE;
  logic       AL_switch;
  logic [4:0] Cur_Hour;
  logic [4:0] Al_Hour;
  logic [5:0] Cur_Min;
  logic [5:0] Al_Min;
  logic [5:0] Cur_Sec;
  logic [1:0] STATE;
  logic       AL_ON;
  logic       Snoozing;

  modport master (
    output Tick_1Hz, BTN_MODE, BTN_SNOOZE, AL_switch,
    output Cur_Hour, Al_Hour, Cur_Min, Al_Min, Cur_Sec,
    input  STATE, AL_ON, Snoozing
  );

  modport slave (
    input  Tick_1Hz, BTN_MODE, BTN_SNOOZE, AL_switch,
    input  Cur_Hour, Al_Hour, Cur_Min, Al_Min, Cur_Sec,
    output STATE, AL_ON, Snoozing
  );
endinterface

// File: rtl/sec_down_counter.sv
// Seconds down-counter: clear, load, tick-enabled decrement and a flag for the tick
// that finds the count at 1 (the final second).
module sec_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = en && !clr && !load && (count == W'(1));

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Display-mode sequencer plus alarm ring/snooze controller for a digital clock.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input logic              Clk,
  input logic              Rst_n,
  alarm_mode_ctrl_if.slave bus
);

  localparam int unsigned CW = timer_width(RING_SEC, SNOOZE_SEC);

  mode_t        mode_q, mode_d;
  alarm_state_t al_q, al_d;
  logic         al_on_q;

  logic match;
  logic cnt_clr;
  logic ring_load;
  logic ring_en;
  logic ring_expire;

  // Mode sequencer
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:       if (bus.BTN_MODE) mode_d = MODE_SET_TIME;
      MODE_SET_TIME:  if (bus.BTN_MODE) mode_d = MODE_SET_ALARM;
      MODE_SET_ALARM: if (bus.BTN_MODE) mode_d = MODE_RUN;
      default:        mode_d = MODE_RUN;
    endcase
  end

  assign bus.STATE = mode_q;

  // Trigger is evaluated regardless of the display mode
  assign match = bus.Tick_1Hz
              && (bus.Cur_Hour == bus.Al_Hour)
              && (bus.Cur_Min  == bus.Al_Min)
              && (bus.Cur_Sec  == '0);

  assign cnt_clr = !bus.AL_switch;
  // A snooze press in the same cycle swallows the tick
  assign ring_en = bus.Tick_1Hz && (al_q == AL_RINGING) && !bus.BTN_SNOOZE;

  sec_down_counter #(.W(CW)) u_ring_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (cnt_clr),
    .load     (ring_load),
    .load_val (CW'(RING_SEC)),
    .en       (ring_en),
    .expire   (ring_expire)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SW = (MAX_SNOOZE > 0) ? int'($clog2(MAX_SNOOZE + 1)) : 1;

  logic [SW-1:0] snooze_cnt;
  logic          snz_load;
  logic          snz_en;
  logic          snz_expire;
  logic          snz_cnt_clr;
  logic          snoozing_q;

  assign snz_en = bus.Tick_1Hz && (al_q == AL_SNOOZE);

  sec_down_counter #(.W(CW)) u_snooze_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (cnt_clr),
    .load     (snz_load),
    .load_val (CW'(SNOOZE_SEC)),
    .en       (snz_en),
    .expire   (snz_expire)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      snooze_cnt <= '0;
    end else if (cnt_clr || snz_cnt_clr) begin
      snooze_cnt <= '0;
    end else if (snz_load) begin
      snooze_cnt <= snooze_cnt + SW'(1);
    end
  end
`else
  // Snooze limit has no meaning without the snooze state
  logic unused_cfg;
  assign unused_cfg = ^MAX_SNOOZE;
`endif

  // Alarm FSM
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      al_q    <= AL_IDLE;
      al_on_q <= 1'b0;
    end else begin
      al_q    <= al_d;
      al_on_q <= (al_d == AL_RINGING);
    end
  end

  always_comb begin
    al_d      = al_q;
    ring_load = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_load    = 1'b0;
    snz_cnt_clr = 1'b0;
`endif
    if (!bus.AL_switch) begin
      al_d = AL_IDLE;
    end else begin
      case (al_q)
        AL_IDLE: begin
          if (match) begin
            al_d      = AL_RINGING;
            ring_load = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_clr = 1'b1;
`endif
          end
        end
        AL_RINGING: begin
          if (bus.BTN_SNOOZE) begin
`ifdef ALARM_SNOOZE_EN
            if (snooze_cnt < SW'(MAX_SNOOZE)) begin
              al_d     = AL_SNOOZE;
              snz_load = 1'b1;
            end else begin
              al_d = AL_IDLE;
            end
`else
            al_d = AL_IDLE;
`endif
          end else if (ring_expire) begin
            al_d = AL_IDLE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        AL_SNOOZE: begin
          if (snz_expire) begin
            al_d      = AL_RINGING;
            ring_load = 1'b1;
          end
        end
`endif
        default: al_d = AL_IDLE;
      endcase
    end
  end

  assign bus.AL_ON = al_on_q;

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      snoozing_q <= 1'b0;
    end else begin
      snoozing_q <= (al_d == AL_SNOOZE);
    end
  end

  assign bus.Snoozing = snoozing_q;
`else
  assign bus.Snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Self-checking bench for alarm_mode_ctrl: directed scenarios then random traffic,
// all compared against a remaining-seconds model of the alarm behaviour.
module tb_alarm_mode_ctrl;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;

  alarm_mode_ctrl_if bus ();

  alarm_mode_ctrl #(
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .MAX_SNOOZE (MAX_SNOOZE)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Model: ringing while m_ring > 0 seconds remain, snoozing while m_snz > 0
  int m_mode;
  int m_ring;
  int m_snz;
  int m_used;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_ring = 0;
    m_snz  = 0;
    m_used = 0;
  endfunction

  function automatic void model_edge();
    if (bus.BTN_MODE) m_mode = (m_mode + 1) % 3;
    if (!bus.AL_switch) begin
      m_ring = 0;
      m_snz  = 0;
      m_used = 0;
    end else if (m_ring > 0) begin
      if (bus.BTN_SNOOZE) begin
        m_ring = 0;
        if (SNZ_EN && (m_used < MAX_SNOOZE)) begin
          m_snz = SNOOZE_SEC;
          m_used++;
        end
      end else if (bus.Tick_1Hz) begin
        m_ring--;
      end
    end else if (m_snz > 0) begin
      if (bus.Tick_1Hz) begin
        m_snz--;
        if (m_snz == 0) m_ring = RING_SEC;
      end
    end else if (bus.Tick_1Hz && (bus.Cur_Hour == bus.Al_Hour) &&
                 (bus.Cur_Min == bus.Al_Min) && (bus.Cur_Sec == 6'd0)) begin
      m_ring = RING_SEC;
      m_used = 0;
    end
  endfunction

  task automatic check_outputs();
    check({phase, " STATE"},    8'(bus.STATE),    8'(m_mode));
    check({phase, " AL_ON"},    8'(bus.AL_ON),    (m_ring > 0) ? 8'd1 : 8'd0);
    check({phase, " Snoozing"}, 8'(bus.Snoozing), (m_snz > 0)  ? 8'd1 : 8'd0);
  endtask

  task automatic step(input logic tick, input logic bm, input logic bs);
    bus.Tick_1Hz   = tick;
    bus.BTN_MODE   = bm;
    bus.BTN_SNOOZE = bs;
    @(posedge Clk);
    model_edge();
    #1;
    bus.Tick_1Hz   = 1'b0;
    bus.BTN_MODE   = 1'b0;
    bus.BTN_SNOOZE = 1'b0;
    check_outputs();
  endtask

  task automatic trigger();
    bus.Cur_Hour = 5'd7;
    bus.Cur_Min  = 6'd30;
    bus.Cur_Sec  = 6'd0;
    step(1'b1, 1'b0, 1'b0);
    bus.Cur_Sec  = 6'd5;
    check({phase, " trigger AL_ON"}, 8'(bus.AL_ON), 8'd1);
  endtask

  task automatic pulse_reset();
    Rst_n = 1'b0;
    #1;
    model_reset();
    check({phase, " async STATE"},    8'(bus.STATE),    8'd0);
    check({phase, " async AL_ON"},    8'(bus.AL_ON),    8'd0);
    check({phase, " async Snoozing"}, 8'(bus.Snoozing), 8'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    logic [1:0] mode_seq [4];
    mode_seq[0] = 2'b01;
    mode_seq[1] = 2'b10;
    mode_seq[2] = 2'b00;
    mode_seq[3] = 2'b01;

    bus.Tick_1Hz   = 1'b0;
    bus.BTN_MODE   = 1'b0;
    bus.BTN_SNOOZE = 1'b0;
    bus.AL_switch  = 1'b0;
    bus.Al_Hour    = 5'd7;
    bus.Al_Min     = 6'd30;
    bus.Cur_Hour   = 5'd0;
    bus.Cur_Min    = 6'd0;
    bus.Cur_Sec    = 6'd0;
    model_reset();

    phase = "reset";
    #2 Rst_n = 1'b0;
    #1 check_outputs();
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    check_outputs();

    phase = "mode";
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("mode_seq", 8'(bus.STATE), 8'(mode_seq[i]));
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    phase = "ring";
    bus.AL_switch = 1'b1;
    bus.Cur_Hour  = 5'd7;
    bus.Cur_Min   = 6'd29;
    bus.Cur_Sec   = 6'd59;
    step(1'b1, 1'b0, 1'b0);
    check("before_match AL_ON", 8'(bus.AL_ON), 8'd0);
    trigger();
    repeat (RING_SEC - 1) step(1'b1, 1'b0, 1'b0);
    check("last_second AL_ON", 8'(bus.AL_ON), 8'd1);
    step(1'b1, 1'b0, 1'b0);
    check("auto_stop AL_ON", 8'(bus.AL_ON), 8'd0);

    phase = "snooze";
    trigger();
    step(1'b0, 1'b0, 1'b1);
`ifdef ALARM_SNOOZE_EN
    check("snooze1 Snoozing", 8'(bus.Snoozing), 8'd1);
    check("snooze1 AL_ON", 8'(bus.AL_ON), 8'd0);
    repeat (SNOOZE_SEC - 1) step(1'b1, 1'b0, 1'b0);
    check("snooze_last Snoozing", 8'(bus.Snoozing), 8'd1);
    step(1'b1, 1'b0, 1'b0);
    check("snooze_expire AL_ON", 8'(bus.AL_ON), 8'd1);
    for (int k = 2; k <= 3; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check("snooze_n Snoozing", 8'(bus.Snoozing), 8'd1);
      repeat (SNOOZE_SEC) step(1'b1, 1'b0, 1'b0);
      check("snooze_n_expire AL_ON", 8'(bus.AL_ON), 8'd1);
    end
    step(1'b0, 1'b0, 1'b1);
    check("fourth_press AL_ON", 8'(bus.AL_ON), 8'd0);
    check("fourth_press Snoozing", 8'(bus.Snoozing), 8'd0);
`else
    check("nosnooze AL_ON", 8'(bus.AL_ON), 8'd0);
    check("nosnooze Snoozing", 8'(bus.Snoozing), 8'd0);
    repeat (SNOOZE_SEC + 20) step(1'b1, 1'b0, 1'b0);
    check("nosnooze_later AL_ON", 8'(bus.AL_ON), 8'd0);
    check("nosnooze_later Snoozing", 8'(bus.Snoozing), 8'd0);
`endif

    phase = "snooze_tick";
    trigger();
    step(1'b1, 1'b0, 1'b1);
    check("snooze_tick AL_ON", 8'(bus.AL_ON), 8'd0);
    bus.AL_switch = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    bus.AL_switch = 1'b1;

    phase = "disarm_snooze";
    trigger();
    bus.AL_switch = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("disarm AL_ON", 8'(bus.AL_ON), 8'd0);
    check("disarm Snoozing", 8'(bus.Snoozing), 8'd0);
    bus.AL_switch = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("disarm_after Snoozing", 8'(bus.Snoozing), 8'd0);

    phase = "reset_mid";
    trigger();
    step(1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0);
    pulse_reset();
    repeat (SNOOZE_SEC + RING_SEC) step(1'b1, 1'b0, 1'b0);
    check("post_reset AL_ON", 8'(bus.AL_ON), 8'd0);

    phase = "random";
    for (int n = 0; n < 15000; n++) begin
      bus.AL_switch = (($urandom % 1500) != 0);
      bus.Cur_Hour  = ($urandom % 2 == 0) ? 5'd7  : 5'($urandom_range(0, 23));
      bus.Cur_Min   = ($urandom % 2 == 0) ? 6'd30 : 6'($urandom_range(0, 59));
      bus.Cur_Sec   = 6'($urandom_range(0, 2));
      if (($urandom % 5000) == 0) pulse_reset();
      step((($urandom % 3) == 0), (($urandom % 12) == 0), (($urandom % 10) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
ALARM_MODE_CTRL -- requirements
Module: alarm_mode_ctrl

Interface
REQ-001 SHALL have parameter RING_SEC, 60, ring duration in Tick_1Hz ticks before auto-stop.
REQ-002 SHALL have parameter SNOOZE_SEC, 300, snooze duration in Tick_1Hz ticks.
REQ-003 SHALL have parameter MAX_SNOOZE, 3, snoozes allowed per alarm event.
REQ-004 SHALL have port Clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Tick_1Hz  input  1  one-Clk-wide enable pulse, once per second.
REQ-007 SHALL have port BTN_MODE  input  1  debounced one-cycle press pulse.
REQ-008 SHALL have port BTN_SNOOZE  input  1  debounced one-cycle press pulse.
REQ-009 SHALL have port AL_switch  input  1  alarm arm switch level, 1 = armed.
REQ-010 SHALL have ports Cur_Hour/Al_Hour  input  5, and Cur_Min/Al_Min  input  6  current and alarm time.
REQ-011 SHALL have port Cur_Sec  input  6  current seconds.
REQ-012 SHALL have port STATE  output  2  display mode: 00 run, 01 set-time, 10 set-alarm.
REQ-013 SHALL have port AL_ON  output  1  alarm ringing.
REQ-014 SHALL have port Snoozing  output  1  alarm in snooze.

Function
REQ-015 Mode FSM SHALL advance STATE 00->01->10->00 on each BTN_MODE pulse, updating on the following Clk edge.
REQ-016 If STATE ever holds 11, the next Clk edge SHALL set it to 00.
REQ-017 Alarm FSM SHALL have states IDLE, RINGING, SNOOZE; AL_ON=1 only in RINGING, Snoozing=1 only in SNOOZE; both are registered.
REQ-018 IDLE->RINGING SHALL occur on a Tick_1Hz cycle when AL_switch=1, Cur_Hour==Al_Hour, Cur_Min==Al_Min and Cur_Sec==0, independent of STATE.
REQ-019 Entering RINGING from IDLE SHALL load the ring counter with RING_SEC and clear the snooze count.
REQ-020 In RINGING each Tick_1Hz SHALL decrement the ring counter; a tick that finds the counter at 1 SHALL move to IDLE.
REQ-021 BTN_SNOOZE in RINGING with snooze count < MAX_SNOOZE SHALL move to SNOOZE, increment the snooze count and load SNOOZE_SEC.
REQ-022 BTN_SNOOZE in RINGING with snooze count == MAX_SNOOZE SHALL move to IDLE.
REQ-023 In SNOOZE each Tick_1Hz SHALL decrement; expiry SHALL return to RINGING with a reloaded RING_SEC.
REQ-024 AL_switch=0 SHALL force IDLE from any state on the next edge and clear all counters; it overrides every simultaneous event.
REQ-025 BTN_SNOOZE together with Tick_1Hz in RINGING: the snooze press SHALL win and the tick SHALL be discarded.
REQ-026 BTN_SNOOZE in IDLE or SNOOZE SHALL be ignored.
REQ-027 A trigger match while already RINGING or in SNOOZE SHALL be ignored.
REQ-028 Counter widths SHALL be $clog2(max(RING_SEC,SNOOZE_SEC)+1); MAX_SNOOZE=0 SHALL make every snooze press a stop.

Reset
REQ-029 Rst_n low SHALL immediately set STATE=00, AL_ON=0, Snoozing=0, alarm FSM=IDLE and all counters to 0.
REQ-030 Reset asserted mid-ring or mid-snooze SHALL abandon the event; no ring SHALL resume after release until the next match.

Configuration
REQ-031 With macro ALARM_SNOOZE_EN defined, snooze behaves as REQ-021..023.
REQ-032 Without ALARM_SNOOZE_EN, the SNOOZE state and its counter SHALL be absent, Snoozing SHALL be tied 0, and BTN_SNOOZE in RINGING SHALL move to IDLE.

Structure
REQ-033 Shared package alarm_pkg SHALL hold the STATE encodings (MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM) and the alarm state typedef.
REQ-034 One sub-module, sec_down_counter (load, Tick_1Hz-enabled decrement, expiry flag), SHALL be used for the ring and snooze timers.

Verification
REQ-035 Four BTN_MODE pulses from reset -> STATE 01, 10, 00, 01.
REQ-036 AL_switch=1, Al=07:30, Cur reaches 07:30:00 on a tick -> AL_ON=1 next edge; after 60 further ticks -> AL_ON=0.
REQ-037 Ringing, BTN_SNOOZE -> Snoozing=1, AL_ON=0; after 300 ticks -> AL_ON=1; 4th snooze press -> IDLE.
REQ-038 Ringing, AL_switch dropped in the same cycle as BTN_SNOOZE -> IDLE, Snoozing stays 0.
REQ-039 Rst_n pulsed low during SNOOZE -> all outputs 0 asynchronously; no AL_ON after release without a new match.
REQ-040 Build without ALARM_SNOOZE_EN; ringing, BTN_SNOOZE -> AL_ON=0, Snoozing=0 permanently.
